alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised sequential ALU, successor to the combinational single-cycle ALU in the MIPS datapath.
- Adds WIDTH generalisation, a valid/ready handshake, and signed/unsigned flags.
- Adds an iterative multiply/divide unit producing HI/LO results.
- Sits between the decode/register-read stage and writeback. The core stalls on `in_ready`/`out_valid`.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request
- ctrl  input  4  operation select (encoding below)
- arg1  input  WIDTH  operand A / dividend / shift source
- arg2  input  WIDTH  operand B / divisor / shift amount (low log2(WIDTH) bits)
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  primary result (LO for mul/div)
- result_hi  output  WIDTH  HI: product upper half or remainder; 0 for single-cycle ops
- zero  output  1  arg1 == arg2, captured at accept
- ovf  output  1  signed overflow for ADD/SUB, else 0
- dbz  output  1  divide by zero (DIV/DIVU with arg2 == 0)
- err  output  1  illegal ctrl

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; in_ready = 1.
  - out_valid, result, result_hi, zero, ovf, dbz, err all = 0.
  - An in-flight mul/div is discarded with no output.
- ctrl encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA.
  - 11 MULTU, 12 MULT, 13 DIVU, 14 DIV.
  - 15 illegal: err = 1, result = 0, result_hi = 0, single-cycle latency.
- Arithmetic is modulo 2^WIDTH.
  - ovf = 1 when operand signs match and the result sign differs (ADD), or operand signs differ and the result sign differs from arg1 (SUB).
  - SLT/SLTU result is 1 or 0, zero-extended.
- Accept: handshake when in_valid && in_ready. in_ready = 1 only in IDLE. Operands and ctrl are registered at accept; later input changes are ignored.
- State machine: IDLE -> EXEC -> FIX -> DONE -> IDLE.
  - IDLE, single-cycle op accepted: the result is computed from the registered operands and presented in DONE; out_valid rises the cycle after accept (latency 1).
  - IDLE, mul/div accepted: go to EXEC with counter = WIDTH, operating on operand magnitudes (signed ops take absolute values).
  - EXEC, MUL: shift-add, one bit per cycle.
  - EXEC, DIV: restoring shift-subtract, one bit per cycle.
  - EXEC exits to FIX when the counter reaches 0 (WIDTH cycles in EXEC).
  - FIX, signed MULT: negate the 2*WIDTH product if operand signs differ.
  - FIX, signed DIV: quotient negated if signs differ; remainder takes the dividend sign.
  - FIX -> DONE. Mul/div out_valid rises WIDTH+2 cycles after accept.
- DONE:
  - out_valid = 1; outputs stable until out_ready.
  - out_valid && out_ready -> IDLE. in_ready returns the following cycle, so there is no accept in the same cycle as the output handshake.
- Divide by zero (detected at accept, still runs the full latency):
  - dbz = 1, result = all ones, result_hi = arg1.
- Signed DIV of most-negative by -1: result = most-negative, result_hi = 0, ovf = 0.
- Shift amount uses only arg2[log2(WIDTH)-1:0]; upper bits are ignored.
- No X on any output in any state; out_valid never glitches within a cycle.

Test Plan:
- Reset mid-MULT (assert rst_n low at cycle 10 after accept): all outputs 0 immediately, in_ready = 1 after release, no out_valid.
- ADD arg1=32'h7FFF_FFFF, arg2=1:
  - out_valid 1 cycle later with result = 32'h8000_0000, ovf = 1, zero = 0.
  - Hold out_ready = 0 for 3 cycles: outputs stable, in_ready = 0.
- MULT arg1 = -3 (32'hFFFF_FFFD), arg2 = 7:
  - out_valid at accept+34.
  - result = 32'hFFFF_FFEB, result_hi = 32'hFFFF_FFFF.
- DIV arg1 = -7, arg2 = 2: result = -3 (32'hFFFF_FFFD), result_hi = -1. DIVU 100/0: dbz = 1, result = 32'hFFFF_FFFF, result_hi = 100.
- SRA arg1 = 32'h8000_0000, arg2 = 32'h0000_0024 (shamt 4): result = 32'hF800_0000. SLT -1 vs 1 -> 1; SLTU -> 0.
- Back-to-back with out_ready tied high:
  - in_valid held, ops ADD then XOR then ctrl=15.
  - Accepts spaced 2 cycles apart.
  - Third op returns err = 1, result = 0.
  - arg1 == arg2 gives zero = 1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle logic/shift/compare ops
// plus an iterative shift-add multiplier and restoring divider producing HI/LO.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             dbz,
  output logic             err
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [SH_W-1:0]    shamt;
  logic               is_muldiv, is_signed;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    shamt   = arg2[SH_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl)
      4'd0: begin
        alu_res = arg1 + arg2;
        alu_ovf = (arg1[WIDTH-1] == arg2[WIDTH-1]) && (alu_res[WIDTH-1] != arg1[WIDTH-1]);
      end
      4'd1: begin
        alu_res = arg1 - arg2;
        alu_ovf = (arg1[WIDTH-1] != arg2[WIDTH-1]) && (alu_res[WIDTH-1] != arg1[WIDTH-1]);
      end
      4'd2:    alu_res = arg1 & arg2;
      4'd3:    alu_res = arg1 | arg2;
      4'd4:    alu_res = arg1 ^ arg2;
      4'd5:    alu_res = ~(arg1 | arg2);
      4'd6:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(arg1) < $signed(arg2))};
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, (arg1 < arg2)};
      4'd8:    alu_res = arg1 << shamt;
      4'd9:    alu_res = arg1 >> shamt;
      4'd10:   alu_res = $signed(arg1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // acc holds {upper product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    is_muldiv = (ctrl >= 4'd11) && (ctrl <= 4'd14);
    is_signed = (ctrl == 4'd12) || (ctrl == 4'd14);
    mag1      = (is_signed && arg1[WIDTH-1]) ? -arg1 : arg1;
    mag2      = (is_signed && arg2[WIDTH-1]) ? -arg2 : arg2;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    dvd_d       = dvd_q;
    is_div_d    = is_div_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_ready_d  = 1'b0;
          zero_d      = (arg1 == arg2);
          ovf_d       = 1'b0;
          dbz_d       = 1'b0;
          err_d       = 1'b0;
          result_hi_d = '0;
          if (is_muldiv) begin
            is_div_d  = (ctrl >= 4'd13);
            acc_d     = {{WIDTH{1'b0}}, (is_div_d ? mag1 : mag2)};
            opnd_d    = is_div_d ? mag2 : mag1;
            neg_res_d = is_signed && (arg1[WIDTH-1] ^ arg2[WIDTH-1]);
            neg_rem_d = is_signed && arg1[WIDTH-1];
            dbz_d     = is_div_d && (arg2 == '0);
            dvd_d     = arg1;
            cnt_d     = CNT_W'(WIDTH);
            state_d   = EXEC;
          end else begin
            result_d    = alu_res;
            ovf_d       = alu_ovf;
            err_d       = (ctrl == 4'hF);
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        // a zero divisor still runs the loop; its fixed result overrides the quotient
        if (is_div_q) begin
          result_d    = dbz_q ? '1 : quo_fix;
          result_hi_d = dbz_q ? dvd_q : rem_fix;
        end else begin
          result_d    = prod_fix[WIDTH-1:0];
          result_hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      dvd_q       <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      dvd_q       <= dvd_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model plus hand-computed literals,
// checked by one negedge compare process against an expectation queue.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ctrl;
  logic [W-1:0] arg1, arg2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result, result_hi;
  logic         zero, ovf, dbz, err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int           due;
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic [3:0]   f;     // {zero, ovf, dbz, err}
    bit           lit;
    logic [W-1:0] lr;
    logic [W-1:0] lhi;
    logic [3:0]   lf;
  } exp_t;

  exp_t expq[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .arg1(arg1), .arg2(arg2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .zero(zero), .ovf(ovf), .dbz(dbz), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain mathematical integer semantics on 64-bit values.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, s, maxs, mins;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic z, o, d, x;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    maxs = 64'sd2147483647;
    mins = -maxs - 1;
    e.r = '0; e.hi = '0; e.due = 0; e.lit = 1'b0; e.lr = '0; e.lhi = '0; e.lf = '0;
    z = (a == b); o = 1'b0; d = 1'b0; x = 1'b0;
    case (c)
      4'd0: begin s = sa + sb; e.r = s[W-1:0]; o = (s > maxs) || (s < mins); end
      4'd1: begin s = sa - sb; e.r = s[W-1:0]; o = (s > maxs) || (s < mins); end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = a ^ b;
      4'd5: e.r = ~(a | b);
      4'd6: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: e.r = (ua < ub) ? 32'd1 : 32'd0;
      4'd8: e.r = a << b[4:0];
      4'd9: e.r = a >> b[4:0];
      4'd10: begin s = sa >>> b[4:0]; e.r = s[W-1:0]; end
      4'd11: begin p = ua * ub; e.r = p[W-1:0]; e.hi = p[63:32]; end
      4'd12: begin s = sa * sb; p = s; e.r = p[W-1:0]; e.hi = p[63:32]; end
      4'd13, 4'd14: begin
        if (b == '0) begin
          d = 1'b1; e.r = '1; e.hi = a;
        end else if (c == 4'd13) begin
          p = ua / ub; e.r = p[W-1:0];
          p = ua % ub; e.hi = p[W-1:0];
        end else begin
          s = sa / sb; e.r = s[W-1:0];
          s = sa % sb; e.hi = s[W-1:0];
        end
      end
      default: x = 1'b1;
    endcase
    e.f = {z, o, d, x};
    return e;
  endfunction

  task automatic push_exp(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit lit, input logic [W-1:0] lr, input logic [W-1:0] lhi,
                          input logic [3:0] lf);
    exp_t e;
    e = model(c, a, b);
    e.due = cyc + (((c >= 4'd11) && (c <= 4'd14)) ? W + 2 : 1);
    e.lit = lit; e.lr = lr; e.lhi = lhi; e.lf = lf;
    expq.push_back(e);
  endtask

  task automatic wait_accept(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit lit, input logic [W-1:0] lr, input logic [W-1:0] lhi,
                             input logic [3:0] lf);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(c, a, b, lit, lr, lhi, lf);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready never rose for ctrl %0d", c);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (expq.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding", expq.size());
      expq.delete();
    end
  endtask

  // One operation; inputs are scrambled after accept to prove they are registered.
  task automatic run(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] lr, input logic [W-1:0] lhi, input logic [3:0] lf);
    @(posedge clk); #1;
    in_valid = 1'b1; ctrl = c; arg1 = a; arg2 = b;
    wait_accept(c, a, b, 1'b1, lr, lhi, lf);
    @(posedge clk); #1;
    in_valid = 1'b0; ctrl = ~c; arg1 = ~a; arg2 = ~b;
    wait_drain();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (expq.size() > 0) begin
        if (cyc < expq[0].due) begin
          chk("early_valid", out_valid, 1'b0);
        end else begin
          chk("valid_at_due", out_valid, 1'b1);
          if (!out_valid) begin
            void'(expq.pop_front());
          end else begin
            chk("result", result, expq[0].r);
            chk("result_hi", result_hi, expq[0].hi);
            chk("flags", {zero, ovf, dbz, err}, expq[0].f);
            chk("in_ready_busy", in_ready, 1'b0);
            if (expq[0].lit) begin
              chk("lit_result", result, expq[0].lr);
              chk("lit_result_hi", result_hi, expq[0].lhi);
              chk("lit_flags", {zero, ovf, dbz, err}, expq[0].lf);
            end
            if (out_ready) void'(expq.pop_front());
          end
        end
      end else begin
        chk("idle_valid", out_valid, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit exceeded at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ctrl = '0; arg1 = '0; arg2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_result_hi", result_hi, 32'h0);
    chk("rst_flags", {zero, ovf, dbz, err}, 4'h0);
    rst_n = 1'b1;

    // ADD overflow with the consumer stalling for 3 cycles
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; ctrl = 4'd0; arg1 = 32'h7FFF_FFFF; arg2 = 32'h1;
    wait_accept(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 32'h0, 4'b0100);
    @(posedge clk); #1;
    in_valid = 1'b0; arg1 = 32'h0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    run(4'd12, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 4'b0000);
    run(4'd14, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0000);
    run(4'd13, 32'd100,       32'h0,         32'hFFFF_FFFF, 32'd100,       4'b0010);
    run(4'd10, 32'h8000_0000, 32'h24,        32'hF800_0000, 32'h0,         4'b0000);
    run(4'd6,  32'hFFFF_FFFF, 32'h1,         32'h1,         32'h0,         4'b0000);
    run(4'd7,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         4'b0000);
    run(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         4'b0000);
    run(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000);
    run(4'd1,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 32'h0,         4'b0100);
    run(4'd8,  32'h1,         32'h21,        32'h2,         32'h0,         4'b0000);
    run(4'd9,  32'h8000_0000, 32'h1F,        32'h1,         32'h0,         4'b0000);
    run(4'd5,  32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0,         4'b1000);
    run(4'd14, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 4'b0010);
    run(4'd13, 32'd100,       32'd7,         32'd14,        32'd2,         4'b0000);
    run(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0,         4'b0000);
    run(4'd3,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 32'h0,         4'b0000);
    run(4'd12, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 4'b0000);
    run(4'd14, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'hC000_0001, 32'h1,         4'b0000);

    // back-to-back with in_valid held and consumer always ready
    @(posedge clk); #1;
    in_valid = 1'b1; ctrl = 4'd0; arg1 = 32'd5; arg2 = 32'd5;
    wait_accept(4'd0, 32'd5, 32'd5, 1'b1, 32'd10, 32'h0, 4'b1000);
    last = cyc;
    @(posedge clk); #1;
    ctrl = 4'd4; arg1 = 32'd3; arg2 = 32'd3;
    wait_accept(4'd4, 32'd3, 32'd3, 1'b1, 32'h0, 32'h0, 4'b1000);
    chk("b2b_spacing_1", cyc - last, 2);
    last = cyc;
    @(posedge clk); #1;
    ctrl = 4'd15; arg1 = 32'd1; arg2 = 32'd2;
    wait_accept(4'd15, 32'd1, 32'd2, 1'b1, 32'h0, 32'h0, 4'b0001);
    chk("b2b_spacing_2", cyc - last, 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // reset in the middle of a MULT: result must be discarded
    @(posedge clk); #1;
    in_valid = 1'b1; ctrl = 4'd12; arg1 = 32'd5; arg2 = 32'd5;
    wait_accept(4'd12, 32'd5, 32'd5, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    expq.delete();
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_result_hi", result_hi, 32'h0);
    chk("midrst_flags", {zero, ovf, dbz, err}, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("postrst_no_valid", out_valid, 1'b0);
    end
    chk("postrst_in_ready", in_ready, 1'b1);

    run(4'd12, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
